step_grid_editor: RTL and testbench

//  Cursor/pattern controller for the step sequencer grid. Consumes the keyboard

---
 rtl/step_grid_editor.sv | 210 +++++++++++++++++++++
 tb/tb_step_grid_editor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_grid_editor.sv
// ----------------------------------------------------------------------------
// step_grid_editor
//
// Purpose:
//   Cursor and pattern controller for the step sequencer grid. It reads the
//   Direction and Command levels from the keyboard decoder, and it gates that
//   decoder through input_en. It moves a cursor over a ROWS x COLS grid and
//   toggles the step bit under the cursor. For every edit it raises one redraw
//   request to the display writer, using a req/ack handshake.
//
// Optional feature (macro GRID_PLAYHEAD_EN):
//   When defined, a playback playhead advances on play_tick && Run.
//   step_hits then pulses the step bits of the column the playhead has just
//   entered. When undefined, playhead and step_hits are tied to 0.
//
// Ports:
//   Clock       in   system clock, rising edge
//   nReset      in   synchronous active-low reset
//   Enable      in   editor active (screen in edit mode)
//   Direction   in   [0]up [1]down [2]left [3]right, level
//   Command     in   toggle step under cursor, level
//   draw_ack    in   display writer accepted the draw request
//   play_tick   in   step-rate strobe (playhead build only)
//   Run         in   playback running (playhead build only)
//   input_en    out  keyboard decoder enable
//   cursor_row  out  cursor row
//   cursor_col  out  cursor column
//   pattern     out  step bits, index = row*COLS + col
//   draw_req    out  redraw request, held until draw_ack
//   draw_row    out  cell to redraw, row
//   draw_col    out  cell to redraw, column
//   playhead    out  playback column
//   step_hits   out  one-cycle pulse of the column just entered
// ----------------------------------------------------------------------------
module step_grid_editor #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 16,
    parameter int unsigned ROW_W = 2,
    parameter int unsigned COL_W = 4
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   Enable,
    input  logic [3:0]             Direction,
    input  logic                   Command,
    input  logic                   draw_ack,
    input  logic                   play_tick,
    input  logic                   Run,
    output logic                   input_en,
    output logic [ROW_W-1:0]       cursor_row,
    output logic [COL_W-1:0]       cursor_col,
    output logic [ROWS*COLS-1:0]   pattern,
    output logic                   draw_req,
    output logic [ROW_W-1:0]       draw_row,
    output logic [COL_W-1:0]       draw_col,
    output logic [COL_W-1:0]       playhead,
    output logic [ROWS-1:0]        step_hits
);

    localparam int unsigned NBITS = ROWS * COLS;

    typedef enum logic [1:0] {StIdle, StEdit, StDraw} state_t;

    state_t               r_state;
    logic [3:0]           r_prev_dir;
    logic                 r_prev_cmd;
    logic                 r_input_en;
    logic [ROW_W-1:0]     r_cursor_row;
    logic [COL_W-1:0]     r_cursor_col;
    logic [NBITS-1:0]     r_pattern;
    logic                 r_draw_req;
    logic [ROW_W-1:0]     r_draw_row;
    logic [COL_W-1:0]     r_draw_col;

    logic                 w_dir_evt;
    logic                 w_cmd_evt;
    logic [ROW_W-1:0]     w_next_row;
    logic [COL_W-1:0]     w_next_col;
    logic [NBITS-1:0]     w_toggle_mask;

    // A chord (non-one-hot Direction) never counts as a key press.
    assign w_dir_evt = $onehot(Direction) && (Direction != r_prev_dir);
    assign w_cmd_evt = Command && !r_prev_cmd;

    assign w_toggle_mask = {{(NBITS-1){1'b0}}, 1'b1} << (r_cursor_row * COLS + r_cursor_col);

    // Wrap at ROWS/COLS explicitly; the grid size need not be a power of 2.
    always_comb begin
        w_next_row = r_cursor_row;
        w_next_col = r_cursor_col;
        if (Direction[0]) begin
            w_next_row = (r_cursor_row == '0) ? ROW_W'(ROWS - 1) : r_cursor_row - 1'b1;
        end else if (Direction[1]) begin
            w_next_row = (r_cursor_row == ROW_W'(ROWS - 1)) ? '0 : r_cursor_row + 1'b1;
        end else if (Direction[2]) begin
            w_next_col = (r_cursor_col == '0) ? COL_W'(COLS - 1) : r_cursor_col - 1'b1;
        end else if (Direction[3]) begin
            w_next_col = (r_cursor_col == COL_W'(COLS - 1)) ? '0 : r_cursor_col + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_state      <= StIdle;
            r_prev_dir   <= '0;
            r_prev_cmd   <= 1'b0;
            r_input_en   <= 1'b0;
            r_cursor_row <= '0;
            r_cursor_col <= '0;
            r_pattern    <= '0;
            r_draw_req   <= 1'b0;
            r_draw_row   <= '0;
            r_draw_col   <= '0;
        end else begin
            r_prev_dir <= Direction;
            r_prev_cmd <= Command;
            unique case (r_state)
                StIdle: begin
                    if (Enable) begin
                        r_state    <= StEdit;
                        r_input_en <= 1'b1;
                    end
                end
                StEdit: begin
                    if (!Enable) begin
                        r_state    <= StIdle;
                        r_input_en <= 1'b0;
                    end else if (w_cmd_evt) begin
                        // A toggle wins over a simultaneous move; the move is dropped.
                        r_pattern  <= r_pattern ^ w_toggle_mask;
                        r_draw_row <= r_cursor_row;
                        r_draw_col <= r_cursor_col;
                        r_draw_req <= 1'b1;
                        r_input_en <= 1'b0;
                        r_state    <= StDraw;
                    end else if (w_dir_evt) begin
                        r_cursor_row <= w_next_row;
                        r_cursor_col <= w_next_col;
                        r_draw_row   <= w_next_row;
                        r_draw_col   <= w_next_col;
                        r_draw_req   <= 1'b1;
                        r_input_en   <= 1'b0;
                        r_state      <= StDraw;
                    end
                end
                StDraw: begin
                    // The handshake always completes, even if Enable drops meanwhile.
                    if (draw_ack) begin
                        r_draw_req <= 1'b0;
                        r_input_en <= Enable;
                        r_state    <= Enable ? StEdit : StIdle;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_input_en <= 1'b0;
                    r_draw_req <= 1'b0;
                end
            endcase
        end
    end

    assign input_en   = r_input_en;
    assign cursor_row = r_cursor_row;
    assign cursor_col = r_cursor_col;
    assign pattern    = r_pattern;
    assign draw_req   = r_draw_req;
    assign draw_row   = r_draw_row;
    assign draw_col   = r_draw_col;

`ifdef GRID_PLAYHEAD_EN
    logic [COL_W-1:0]     r_playhead;
    logic [ROWS-1:0]      r_step_hits;
    logic [COL_W-1:0]     w_next_play;
    logic [NBITS-1:0]     w_shifted;
    logic [ROWS-1:0]      w_col_bits;

    assign w_next_play = (r_playhead == COL_W'(COLS - 1)) ? '0 : r_playhead + 1'b1;
    // Shift the entered column down to bit 0 of each row.
    assign w_shifted   = r_pattern >> w_next_play;

    always_comb begin
        w_col_bits = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            w_col_bits[r] = w_shifted[r*COLS];
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_playhead  <= '0;
            r_step_hits <= '0;
        end else if (play_tick && Run) begin
            r_playhead  <= w_next_play;
            r_step_hits <= w_col_bits;
        end else begin
            r_step_hits <= '0;
        end
    end

    assign playhead  = r_playhead;
    assign step_hits = r_step_hits;
`else
    logic w_unused;
    assign w_unused  = ^{play_tick, Run};
    assign playhead  = '0;
    assign step_hits = '0;
`endif

endmodule

// File: tb/tb_step_grid_editor.sv
// ----------------------------------------------------------------------------
// tb_step_grid_editor
//
// Purpose:
//   Self-checking bench for step_grid_editor with the default 4x16 grid. It
//   applies a table of per-cycle vectors with hand-computed expected outputs.
//   It then runs directed sequences for toggling, for a reset in the middle of
//   a draw, and for the playhead. The playhead expectations follow the
//   GRID_PLAYHEAD_EN macro.
// ----------------------------------------------------------------------------
module tb_step_grid_editor;

    logic        Clock;
    logic        nReset;
    logic        Enable;
    logic [3:0]  Direction;
    logic        Command;
    logic        draw_ack;
    logic        play_tick;
    logic        Run;
    logic        input_en;
    logic [1:0]  cursor_row;
    logic [3:0]  cursor_col;
    logic [63:0] pattern;
    logic        draw_req;
    logic [1:0]  draw_row;
    logic [3:0]  draw_col;
    logic [3:0]  playhead;
    logic [3:0]  step_hits;

    int n_tests = 0;
    int n_fail  = 0;

    step_grid_editor #(
        .ROWS  (4),
        .COLS  (16),
        .ROW_W (2),
        .COL_W (4)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Enable     (Enable),
        .Direction  (Direction),
        .Command    (Command),
        .draw_ack   (draw_ack),
        .play_tick  (play_tick),
        .Run        (Run),
        .input_en   (input_en),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .pattern    (pattern),
        .draw_req   (draw_req),
        .draw_row   (draw_row),
        .draw_col   (draw_col),
        .playhead   (playhead),
        .step_hits  (step_hits)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        en;
        logic [3:0]  dir;
        logic        cmd;
        logic        ack;
        logic        x_en;
        logic [1:0]  x_row;
        logic [3:0]  x_col;
        logic        x_req;
        logic [1:0]  x_drow;
        logic [3:0]  x_dcol;
        logic [63:0] x_pat;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mkv(input logic en, input logic [3:0] dir, input logic cmd,
                                 input logic ack, input logic x_en, input logic [1:0] x_row,
                                 input logic [3:0] x_col, input logic x_req,
                                 input logic [1:0] x_drow, input logic [3:0] x_dcol,
                                 input logic [63:0] x_pat);
        vec_t v;
        v.en = en; v.dir = dir; v.cmd = cmd; v.ack = ack;
        v.x_en = x_en; v.x_row = x_row; v.x_col = x_col; v.x_req = x_req;
        v.x_drow = x_drow; v.x_dcol = x_dcol; v.x_pat = x_pat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic en, input logic [3:0] dir, input logic cmd, input logic ack);
        Enable    = en;
        Direction = dir;
        Command   = cmd;
        draw_ack  = ack;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_move(input logic [3:0] dir);
        step(1'b1, dir, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic do_toggle();
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
    endtask

    logic [3:0] exp_ph;
    logic [3:0] exp_hits;

    initial begin
        //           en    dir      cmd   ack    x_en  row    col     req   drow   dcol    pat
        vecs[0]  = mkv(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  64'h0);
        vecs[1]  = mkv(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0,  1'b1, 2'd3, 4'd0,  64'h0);
        vecs[2]  = mkv(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0,  1'b1, 2'd3, 4'd0,  64'h0);
        vecs[3]  = mkv(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0,  1'b1, 2'd3, 4'd0,  64'h0);
        vecs[4]  = mkv(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd3, 4'd0,  1'b0, 2'd3, 4'd0,  64'h0);
        vecs[5]  = mkv(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd3, 4'd0,  1'b0, 2'd3, 4'd0,  64'h0);
        vecs[6]  = mkv(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'd0,  1'b0, 2'd3, 4'd0,  64'h0);
        vecs[7]  = mkv(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd0, 4'd0,  64'h0);
        vecs[8]  = mkv(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  64'h0);
        vecs[9]  = mkv(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'd15, 1'b1, 2'd0, 4'd15, 64'h0);
        vecs[10] = mkv(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd0, 4'd15, 1'b0, 2'd0, 4'd15, 64'h0);
        vecs[11] = mkv(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd0, 4'd0,  64'h0);
        vecs[12] = mkv(1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  64'h0);
        vecs[13] = mkv(1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  64'h0);
        vecs[14] = mkv(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  64'h0);
        vecs[15] = mkv(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1,  1'b1, 2'd0, 4'd1,  64'h0);
        vecs[16] = mkv(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1,  1'b1, 2'd0, 4'd1,  64'h0);
        vecs[17] = mkv(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h0);
        vecs[18] = mkv(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h0);
        vecs[19] = mkv(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h0);
        vecs[20] = mkv(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1,  1'b1, 2'd0, 4'd1,  64'h2);
        vecs[21] = mkv(1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h2);
        vecs[22] = mkv(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h2);
        vecs[23] = mkv(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1,  1'b1, 2'd0, 4'd1,  64'h0);
        vecs[24] = mkv(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1,  1'b1, 2'd0, 4'd1,  64'h0);
        vecs[25] = mkv(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h0);
        vecs[26] = mkv(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1,  1'b0, 2'd0, 4'd1,  64'h0);

        nReset    = 1'b0;
        play_tick = 1'b0;
        Run       = 1'b0;
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        check("reset input_en", 64'(input_en), 64'h0);
        check("reset cursor", 64'({cursor_row, cursor_col}), 64'h0);
        check("reset pattern", pattern, 64'h0);
        check("reset draw_req", 64'(draw_req), 64'h0);
        check("reset draw cell", 64'({draw_row, draw_col}), 64'h0);
        check("reset playhead", 64'({playhead, step_hits}), 64'h0);
        nReset = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step(vecs[i].en, vecs[i].dir, vecs[i].cmd, vecs[i].ack);
            check($sformatf("v%0d input_en", i), 64'(input_en), 64'(vecs[i].x_en));
            check($sformatf("v%0d cursor_row", i), 64'(cursor_row), 64'(vecs[i].x_row));
            check($sformatf("v%0d cursor_col", i), 64'(cursor_col), 64'(vecs[i].x_col));
            check($sformatf("v%0d draw_req", i), 64'(draw_req), 64'(vecs[i].x_req));
            if (vecs[i].x_req) begin
                check($sformatf("v%0d draw_row", i), 64'(draw_row), 64'(vecs[i].x_drow));
                check($sformatf("v%0d draw_col", i), 64'(draw_col), 64'(vecs[i].x_dcol));
            end
            check($sformatf("v%0d pattern", i), pattern, vecs[i].x_pat);
        end

        // Walk from (0,1) to (2,5) and toggle bit 37 on and off.
        do_move(4'b0010);
        do_move(4'b0010);
        for (int k = 0; k < 4; k++) do_move(4'b1000);
        check("walk cursor", 64'({cursor_row, cursor_col}), 64'({2'd2, 4'd5}));
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("toggle37 on", 64'(pattern[37]), 64'h1);
        check("toggle37 draw", 64'({draw_req, draw_row, draw_col}), 64'({1'b1, 2'd2, 4'd5}));
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        check("toggle37 ack", 64'({draw_req, input_en}), 64'({1'b0, 1'b1}));
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("toggle37 off", pattern, 64'h0);
        step(1'b1, 4'b0000, 1'b0, 1'b1);

        // A reset during DRAW drops draw_req without an ack.
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("middraw req", 64'(draw_req), 64'h1);
        nReset = 1'b0;
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("middraw reset req", 64'(draw_req), 64'h0);
        check("middraw reset state", 64'({input_en, cursor_row, cursor_col}), 64'h0);
        check("middraw reset pattern", pattern, 64'h0);
        nReset = 1'b1;

        // Set bits at (0,1) and (2,1), then drive the playhead.
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        do_move(4'b1000);
        do_toggle();
        do_move(4'b0010);
        do_move(4'b0010);
        do_toggle();
        check("ph pattern", pattern, 64'h0000_0002_0000_0002);
        Run = 1'b1; play_tick = 1'b1;
        step(1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef GRID_PLAYHEAD_EN
        exp_ph = 4'd1; exp_hits = 4'b0101;
`else
        exp_ph = 4'd0; exp_hits = 4'b0000;
`endif
        check("ph tick0 playhead", 64'(playhead), 64'(exp_ph));
        check("ph tick0 hits", 64'(step_hits), 64'(exp_hits));
        play_tick = 1'b0;
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("ph hits pulse", 64'(step_hits), 64'h0);
        check("ph hold", 64'(playhead), 64'(exp_ph));
        Run = 1'b0; play_tick = 1'b1;
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("ph run0 hold", 64'({playhead, step_hits}), 64'({exp_ph, 4'b0000}));
        Run = 1'b1;
        for (int k = 0; k < 14; k++) step(1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef GRID_PLAYHEAD_EN
        exp_ph = 4'd15;
`endif
        check("ph at 15", 64'(playhead), 64'(exp_ph));
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("ph wrap", 64'({playhead, step_hits}), 64'h0);
        play_tick = 1'b0; Run = 1'b0;
        step(1'b1, 4'b0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
